lzc_norm_pipe: RTL and testbench
================================

# lzc_norm_pipe

Pipelined, parametrised leading-zero counter and normaliser for the floating-point datapath of the systolic-array processing element. It generalises the fixed-width (24/53) leading-zero detector to any width and adds a leading-sign-count mode for two's-complement accumulators. It also adds the normalising left shift, a full-width count that encodes the all-zero case without overflow, a pass-through tag and valid/ready handshakes on both sides. It sits between the mantissa adder and the rounding stage.

## Interface
- WIDTH, 24, data width; any value 2..64.
- STAGES, 2, pipeline depth; 1 = count and shift in one registered stage, 2 = count registered, then shift registered.
- TAG_W, 4, width of sideband tag carried alongside the data.
- LZW, $clog2(WIDTH+1), derived; width of the count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  value to normalise.
- in_mode  in  1  0 = count leading zeros; 1 = count redundant sign bits.
- in_tag  in  TAG_W  opaque sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_lz  out  LZW  shift amount applied.
- out_norm  out  WIDTH  in_data << out_lz, zero-filled.
- out_zero  out  1  in_data was all zeros (mode 0) or all sign bits (mode 1).
- out_tag  out  TAG_W  in_tag of the same beat.

## Operation
- Beat accepted on in_valid && in_ready; result delivered on out_valid && out_ready.
- Mode 0: out_lz = number of zeros above the highest 1; in_data = 0 gives out_lz = WIDTH, out_norm = 0, out_zero = 1.
- Mode 1: out_lz = count of leading bits equal to in_data[WIDTH-1], minus 1. Bit WIDTH-1 of out_norm then differs from bit WIDTH-2.
  - All-zero or all-one input gives out_lz = WIDTH-1 and out_zero = 1.
- out_lz is never greater than WIDTH; the count is LZW bits wide so WIDTH is representable (the all-zero count must not wrap).
- Count logic is a generic priority/tree structure valid for every legal WIDTH, not per-width case tables.
- Each stage holds one valid bit plus its payload. A stage loads when it is empty or its contents advance in the same cycle.
- in_ready = !stage1_valid || stage1_advances. This is combinational from out_ready through the stage chain; no skid buffer is required.
- Full throughput: one beat per cycle when out_ready stays high.
- Stalled stages hold their payload bit-exact. out_* is stable while out_valid && !out_ready.
- Beats never reorder, duplicate or drop; out_tag always matches its data.
- STAGES = 2: stage 1 registers in_data, in_tag, the count and zero flag; stage 2 registers the shifted data.
- STAGES = 1: count and shift both complete before the single register.
- WIDTH outside 2..64 or STAGES outside 1..2: elaboration error.

## Timing
- Latency: out_valid rises STAGES cycles after the accepting edge when there is no back-pressure.
- Reset (async assert, released synchronously to clk by the environment):
  - All stage valid bits clear, so out_valid = 0 and in_ready = 1 out of reset.
  - out_lz, out_norm, out_zero and out_tag read 0.
- Reset mid-operation discards every in-flight beat; nothing emerges after deassertion.
- A full pipe with out_ready = 1 accepts a new beat in the same cycle one leaves; in_ready stays 1.
- A full pipe with out_ready = 0 gives in_ready = 0 within the same cycle.
- in_mode is sampled only on acceptance; changing it between beats has no effect on in-flight results.

## Test plan
- WIDTH=24, STAGES=2, mode 0, in_data=24'h00_1000 then 24'h80_0000, out_ready=1 -> out_lz=11, out_norm=24'h80_0000; next cycle out_lz=0; first out_valid exactly 2 cycles after accept.
- WIDTH=24, mode 0, in_data=0 -> out_lz=24, out_norm=0, out_zero=1. WIDTH=53, in_data=1 -> out_lz=52, out_norm=1<<52.
- WIDTH=16, mode 1: in_data=16'hFFF0 -> out_lz=11, out_norm=16'h8000; in_data=16'h0003 -> out_lz=13, out_norm=16'h6000; in_data=16'hFFFF -> out_lz=15, out_zero=1.
- Back-pressure: stream 8 beats with tags 0..7, out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs hold stable, all 8 emerge in order with matching tags and no duplicates.
- Assert rst while 2 beats are in flight -> out_valid=0 and in_ready=1 immediately; no stale beats after release.
- Random sweep, STAGES in {1,2}, WIDTH in {2,24,53,64}, random valid/ready -> every result matches a reference model; throughput is 1 per cycle when out_ready is held at 1.

Source files
------------

// File: rtl/lzc_norm_pipe_if.sv
`default_nettype none
// =============================================================================
// Module   : lzc_norm_pipe_if
// Purpose  : Beat-level handshake bundle between lzc_norm_pipe and its neighbours.
// Revision : 1.0 - initial release
// =============================================================================
interface lzc_norm_pipe_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4,
  parameter int LZW   = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [LZW-1:0]   out_lz;
  logic [WIDTH-1:0] out_norm;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_lz, out_norm, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_lz, out_norm, out_zero, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// =============================================================================
// Module   : lzc_norm_pipe
// Purpose  : Pipelined leading-zero / redundant-sign counter with normalising shift.
// Revision : 1.0 - initial release
// =============================================================================
module lzc_norm_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int LZW    = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  lzc_norm_pipe_if.slave bus
);

  if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
    $error("lzc_norm_pipe: WIDTH must lie in 2..64");
  end
  if ((STAGES < 1) || (STAGES > 2)) begin : g_bad_stages
    $error("lzc_norm_pipe: STAGES must be 1 or 2");
  end

  // Sign mode marks each bit that differs from its upper neighbour; bit 0 is a
  // sentinel so a run spanning the whole word stops at WIDTH-1.
  logic [WIDTH-1:0] scan_vec;
  logic [LZW-1:0]   cnt_in;
  logic             zero_in;

  always_comb begin
    scan_vec    = '0;
    scan_vec[0] = bus.in_mode ? 1'b1 : bus.in_data[0];
    for (int i = 1; i < WIDTH; i++) begin
      scan_vec[i] = bus.in_mode ? (bus.in_data[i] ^ bus.in_data[i-1]) : bus.in_data[i];
    end
  end

  always_comb begin
    cnt_in = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (scan_vec[i]) cnt_in = LZW'(WIDTH - 1 - i);
    end
    zero_in = bus.in_mode ? (cnt_in == LZW'(WIDTH - 1)) : (cnt_in == LZW'(WIDTH));
  end

  if (STAGES == 2) begin : g_two
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic [LZW-1:0]   s1_lz_q,    s1_lz_d;
    logic             s1_zero_q,  s1_zero_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;
    logic [LZW-1:0]   s2_lz_q,    s2_lz_d;
    logic             s2_zero_q,  s2_zero_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic             s2_open;
    logic             s1_open;

    always_comb begin
      s2_open    = !s2_valid_q || bus.out_ready;
      s1_open    = !s1_valid_q || s2_open;
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_lz_d    = s1_lz_q;
      s1_zero_d  = s1_zero_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_norm_d  = s2_norm_q;
      s2_lz_d    = s2_lz_q;
      s2_zero_d  = s2_zero_q;
      s2_tag_d   = s2_tag_q;
      if (s2_open) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_norm_d = s1_data_q << s1_lz_q;
          s2_lz_d   = s1_lz_q;
          s2_zero_d = s1_zero_q;
          s2_tag_d  = s1_tag_q;
        end
      end
      if (s1_open) begin
        s1_valid_d = bus.in_valid;
        if (bus.in_valid) begin
          s1_data_d = bus.in_data;
          s1_lz_d   = cnt_in;
          s1_zero_d = zero_in;
          s1_tag_d  = bus.in_tag;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        s1_lz_q    <= '0;
        s1_zero_q  <= 1'b0;
        s1_tag_q   <= '0;
        s2_valid_q <= 1'b0;
        s2_norm_q  <= '0;
        s2_lz_q    <= '0;
        s2_zero_q  <= 1'b0;
        s2_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
        s1_lz_q    <= s1_lz_d;
        s1_zero_q  <= s1_zero_d;
        s1_tag_q   <= s1_tag_d;
        s2_valid_q <= s2_valid_d;
        s2_norm_q  <= s2_norm_d;
        s2_lz_q    <= s2_lz_d;
        s2_zero_q  <= s2_zero_d;
        s2_tag_q   <= s2_tag_d;
      end
    end

    assign bus.in_ready  = s1_open;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_lz    = s2_lz_q;
    assign bus.out_norm  = s2_norm_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_tag   = s2_tag_q;
  end else begin : g_one
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_norm_q,  s1_norm_d;
    logic [LZW-1:0]   s1_lz_q,    s1_lz_d;
    logic             s1_zero_q,  s1_zero_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s1_open;

    always_comb begin
      s1_open    = !s1_valid_q || bus.out_ready;
      s1_valid_d = s1_valid_q;
      s1_norm_d  = s1_norm_q;
      s1_lz_d    = s1_lz_q;
      s1_zero_d  = s1_zero_q;
      s1_tag_d   = s1_tag_q;
      if (s1_open) begin
        s1_valid_d = bus.in_valid;
        if (bus.in_valid) begin
          s1_norm_d = bus.in_data << cnt_in;
          s1_lz_d   = cnt_in;
          s1_zero_d = zero_in;
          s1_tag_d  = bus.in_tag;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_norm_q  <= '0;
        s1_lz_q    <= '0;
        s1_zero_q  <= 1'b0;
        s1_tag_q   <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_norm_q  <= s1_norm_d;
        s1_lz_q    <= s1_lz_d;
        s1_zero_q  <= s1_zero_d;
        s1_tag_q   <= s1_tag_d;
      end
    end

    assign bus.in_ready  = s1_open;
    assign bus.out_valid = s1_valid_q;
    assign bus.out_lz    = s1_lz_q;
    assign bus.out_norm  = s1_norm_q;
    assign bus.out_zero  = s1_zero_q;
    assign bus.out_tag   = s1_tag_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
`default_nettype none
// =============================================================================
// Module   : tb_lzc_norm_pipe
// Purpose  : Directed and randomised scoreboard bench over several WIDTH/STAGES builds.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_lzc_norm_pipe;
  localparam int NCFG = 9;

  function automatic int cfg_w(int i);
    case (i)
      0: return 24;  1: return 16;  2: return 53;  3: return 2;  4: return 24;
      5: return 64;  6: return 64;  7: return 53;  default: return 2;
    endcase
  endfunction

  function automatic int cfg_s(int i);
    case (i)
      3, 4, 6, 7: return 1;
      default:    return 2;
    endcase
  endfunction

  typedef struct packed {
    logic [6:0]  lz;
    logic [63:0] norm;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        drv_valid [NCFG];
  logic        drv_ready [NCFG];
  logic        drv_mode  [NCFG];
  logic [63:0] drv_data  [NCFG];
  logic [3:0]  drv_tag   [NCFG];

  logic        obs_in_ready  [NCFG];
  logic        obs_out_valid [NCFG];
  logic [6:0]  obs_lz        [NCFG];
  logic [63:0] obs_norm      [NCFG];
  logic        obs_zero      [NCFG];
  logic [3:0]  obs_tag       [NCFG];

  res_t sbq    [NCFG][$];
  res_t held   [NCFG];
  logic held_v [NCFG];
  int   n_out  [NCFG];
  int   acc    [NCFG];
  int   n_assert;
  int   n_fail;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    lzc_norm_pipe_if #(.WIDTH(W), .TAG_W(4)) bus ();
    lzc_norm_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.in_valid      = drv_valid[g];
    assign bus.in_data       = drv_data[g][W-1:0];
    assign bus.in_mode       = drv_mode[g];
    assign bus.in_tag        = drv_tag[g];
    assign bus.out_ready     = drv_ready[g];
    assign obs_in_ready[g]   = bus.in_ready;
    assign obs_out_valid[g]  = bus.out_valid;
    assign obs_lz[g]         = 7'(bus.out_lz);
    assign obs_norm[g]       = 64'(bus.out_norm);
    assign obs_zero[g]       = bus.out_zero;
    assign obs_tag[g]        = bus.out_tag;
  end

  // Reference: walk down from the MSB counting the leading run.
  function automatic res_t model(int w, logic mode, logic [63:0] din, logic [3:0] tag);
    res_t        r;
    logic [63:0] mask;
    logic [63:0] d;
    logic        top;
    logic        run;
    int          cnt;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = din & mask;
    top  = d[w-1];
    cnt  = 0;
    run  = 1'b1;
    for (int b = w - 1; b >= 0; b--) begin
      if (run && (d[b] == (mode ? top : 1'b0))) cnt++;
      else run = 1'b0;
    end
    r.lz   = 7'(mode ? cnt - 1 : cnt);
    r.zero = (cnt == w);
    r.norm = (d << r.lz) & mask;
    r.tag  = tag;
    return r;
  endfunction

  task automatic chk_bit(string name, logic got, logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(string name, int got, int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_res(string name, res_t got, res_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed lz=%0d norm=%h zero=%b tag=%h expected lz=%0d norm=%h zero=%b tag=%h",
             name, got.lz, got.norm, got.zero, got.tag, exp.lz, exp.norm, exp.zero, exp.tag);
    end
  endtask

  // Negedge sampling: hold check, output pop/compare, input push.
  task automatic to_neg();
    res_t cur;
    res_t exp;
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      if (rst) begin
        sbq[i].delete();
        held_v[i] = 1'b0;
      end else begin
        cur = {obs_lz[i], obs_norm[i], obs_zero[i], obs_tag[i]};
        if (held_v[i]) begin
          chk_bit($sformatf("hold_valid[%0d]", i), obs_out_valid[i], 1'b1);
          chk_res($sformatf("hold_payload[%0d]", i), cur, held[i]);
        end
        if (obs_out_valid[i] && drv_ready[i]) begin
          if (sbq[i].size() == 0) begin
            chk_int($sformatf("sb_extra_beat[%0d]", i), sbq[i].size(), 1);
          end else begin
            exp = sbq[i].pop_front();
            chk_res($sformatf("sb_result[%0d]", i), cur, exp);
            n_out[i]++;
          end
        end
        held_v[i] = obs_out_valid[i] && !drv_ready[i];
        held[i]   = cur;
        if (drv_valid[i] && obs_in_ready[i])
          sbq[i].push_back(model(cfg_w(i), drv_mode[i], drv_data[i], drv_tag[i]));
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int i, logic mode, logic [63:0] data, logic [3:0] tag);
    drv_valid[i] = 1'b1;
    drv_ready[i] = 1'b1;
    drv_mode[i]  = mode;
    drv_data[i]  = data;
    drv_tag[i]   = tag;
  endtask

  task automatic idle(int i);
    drv_valid[i] = 1'b0;
    drv_ready[i] = 1'b1;
  endtask

  task automatic rand_payload(int i);
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       drv_data[i] = 64'd0;
      1:       drv_data[i] = {64{1'b1}};
      default: drv_data[i] = r64 >> $urandom_range(0, 63);
    endcase
    drv_mode[i] = 1'($urandom_range(0, 1));
    drv_tag[i]  = 4'($urandom());
  endtask

  task automatic expect_out(int i, string name, logic [6:0] lz, logic [63:0] norm,
                            logic zero, logic [3:0] tag);
    res_t cur;
    res_t exp;
    cur = {obs_lz[i], obs_norm[i], obs_zero[i], obs_tag[i]};
    exp = {lz, norm, zero, tag};
    chk_bit({name, "_valid"}, obs_out_valid[i], 1'b1);
    chk_res(name, cur, exp);
  endtask

  initial begin
    int k;
    int base;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      drv_valid[i] = 1'b0;
      drv_ready[i] = 1'b1;
      drv_mode[i]  = 1'b0;
      drv_data[i]  = 64'd0;
      drv_tag[i]   = 4'd0;
      held_v[i]    = 1'b0;
      n_out[i]     = 0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state on every build.
    to_neg();
    for (int i = 0; i < NCFG; i++) begin
      chk_bit("rst_out_valid", obs_out_valid[i], 1'b0);
      chk_bit("rst_in_ready", obs_in_ready[i], 1'b1);
      chk_res("rst_payload", {obs_lz[i], obs_norm[i], obs_zero[i], obs_tag[i]}, '0);
    end
    to_pos();
    rst = 1'b0;
    to_neg();
    to_pos();

    // Directed values and latency on W24/S2, W16/S2 sign mode, W53/S2.
    beat(0, 1'b0, 64'h001000, 4'd1);
    beat(1, 1'b1, 64'hFFF0, 4'd3);
    beat(2, 1'b0, 64'd1, 4'd7);
    to_neg(); chk_bit("lat_c0_valid", obs_out_valid[0], 1'b0); to_pos();
    beat(0, 1'b0, 64'h800000, 4'd2);
    beat(1, 1'b1, 64'h0003, 4'd4);
    idle(2);
    to_neg(); chk_bit("lat_c1_valid", obs_out_valid[0], 1'b0); to_pos();
    beat(0, 1'b0, 64'h000000, 4'd3);
    beat(1, 1'b1, 64'hFFFF, 4'd5);
    to_neg();
    expect_out(0, "w24_a", 7'd11, 64'h800000, 1'b0, 4'd1);
    expect_out(1, "w16_fff0", 7'd11, 64'h8000, 1'b0, 4'd3);
    expect_out(2, "w53_one", 7'd52, 64'd1 << 52, 1'b0, 4'd7);
    to_pos();
    idle(0);
    idle(1);
    to_neg();
    expect_out(0, "w24_b", 7'd0, 64'h800000, 1'b0, 4'd2);
    expect_out(1, "w16_0003", 7'd13, 64'h6000, 1'b0, 4'd4);
    to_pos();
    to_neg();
    expect_out(0, "w24_zero", 7'd24, 64'd0, 1'b1, 4'd3);
    expect_out(1, "w16_ffff", 7'd15, 64'h8000, 1'b1, 4'd5);
    to_pos();
    to_neg(); chk_bit("w24_idle", obs_out_valid[0], 1'b0); to_pos();

    // Back-pressure: 8 tagged beats with out_ready low for three cycles.
    k    = 0;
    base = n_out[0];
    for (int c = 0; c < 24; c++) begin
      drv_ready[0] = !((c >= 3) && (c < 6));
      drv_valid[0] = (k < 8);
      drv_tag[0]   = 4'(k);
      drv_mode[0]  = k[0];
      drv_data[0]  = 64'(((k + 1) * 32'h1357) & 32'hFFFFFF);
      to_neg();
      if (c == 4) chk_bit("bp_in_ready_low", obs_in_ready[0], 1'b0);
      if (drv_valid[0] && obs_in_ready[0]) k++;
      to_pos();
    end
    idle(0);
    chk_int("bp_beats_out", n_out[0] - base, 8);

    // Reset with two beats in flight.
    beat(0, 1'b0, 64'h000F00, 4'd9);
    to_neg(); to_pos();
    beat(0, 1'b0, 64'h0000F0, 4'd10);
    to_neg(); to_pos();
    idle(0);
    rst = 1'b1;
    #1;
    chk_bit("midrst_out_valid", obs_out_valid[0], 1'b0);
    chk_bit("midrst_in_ready", obs_in_ready[0], 1'b1);
    to_neg(); to_pos();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      to_neg(); chk_bit("post_rst_quiet", obs_out_valid[0], 1'b0); to_pos();
    end

    // Full throughput with out_ready held high.
    for (int i = 0; i < NCFG; i++) begin
      drv_valid[i] = 1'b1;
      drv_ready[i] = 1'b1;
      acc[i]       = 0;
    end
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NCFG; i++) rand_payload(i);
      to_neg();
      for (int i = 0; i < NCFG; i++) if (obs_in_ready[i]) acc[i]++;
      to_pos();
    end
    for (int i = 0; i < NCFG; i++) chk_int($sformatf("throughput[%0d]", i), acc[i], 40);

    // Random valid/ready sweep across all builds.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCFG; i++) begin
        rand_payload(i);
        drv_valid[i] = ($urandom_range(0, 99) < 70);
        drv_ready[i] = ($urandom_range(0, 99) < 65);
      end
      to_neg();
      to_pos();
    end

    for (int i = 0; i < NCFG; i++) idle(i);
    repeat (6) begin
      to_neg();
      to_pos();
    end
    for (int i = 0; i < NCFG; i++) chk_int($sformatf("drain_empty[%0d]", i), sbq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
